// File: rtl/ofdm_bit_feeder.sv
// ofdm_bit_feeder: upstream source stage for OFDM_Top.
// Accepts DATA_W-bit words over valid/ready into a small FIFO and serialises
// them LSB first as GROUP_BITS-bit groups, separated by idle gaps, framed by go.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_data/in_valid     input word and its valid
//   in_ready             FIFO can accept (registered)
//   top_busy             OFDM_Top busy, sampled only at group start
//   signal_out, go_out   serial bit and frame-active to OFDM_Top
//   frame_done           one-cycle pulse after the last bit of a frame
//   underrun             sticky: FIFO was empty when a mid-frame group needed a word
module ofdm_bit_feeder #(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned GROUP_BITS       = 4,
    parameter int unsigned GAP_CYCLES       = 5,
    parameter int unsigned GROUPS_PER_FRAME = 8,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              top_busy,
    output logic              signal_out,
    output logic              go_out,
    output logic              frame_done,
    output logic              underrun
);

    localparam int unsigned WORD_GROUPS = DATA_W / GROUP_BITS;
    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W       = $clog2(GROUP_BITS + 1);
    localparam int unsigned GRP_W       = $clog2(GROUPS_PER_FRAME + 1);
    localparam int unsigned GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WG_W        = $clog2(WORD_GROUPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_d;
    logic              push_c, pop_c, fifo_empty_c;
    logic [DATA_W-1:0] fifo_head_c;

    // Serialiser state
    logic [1:0]        state, state_d;
    logic [DATA_W-1:0] sreg, sreg_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [GRP_W-1:0]  grp_cnt, grp_cnt_d, grp_inc_c;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
    logic [WG_W-1:0]   word_grp, word_grp_d;
    logic              signal_d, go_d, frame_done_d, underrun_d, load_c;

    assign push_c       = in_valid & in_ready;
    assign fifo_empty_c = (count == '0);
    assign fifo_head_c  = mem[rd_ptr];
    assign grp_inc_c    = grp_cnt + GRP_W'(1);

    // Occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count;
        case ({push_c, pop_c})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Storage array carries no reset; pointers and count define its contents
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= in_data;
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state;
        sreg_d       = sreg;
        bit_cnt_d    = bit_cnt;
        grp_cnt_d    = grp_cnt;
        gap_cnt_d    = gap_cnt;
        word_grp_d   = word_grp;
        signal_d     = 1'b0;
        go_d         = go_out;
        frame_done_d = 1'b0;
        underrun_d   = underrun;
        pop_c        = 1'b0;
        load_c       = 1'b0;
        case (state)
            // DONE behaves like IDLE so a queued frame can start right after it
            S_IDLE, S_DONE: begin
                state_d    = S_IDLE;
                go_d       = 1'b0;
                bit_cnt_d  = '0;
                grp_cnt_d  = '0;
                gap_cnt_d  = '0;
                word_grp_d = '0;
                if (!fifo_empty_c && !top_busy) load_c = 1'b1;
            end
            S_SHIFT: begin
                if (bit_cnt != BIT_W'(GROUP_BITS)) begin
                    signal_d  = sreg[0];
                    sreg_d    = sreg >> 1;
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                end else begin
                    grp_cnt_d = grp_inc_c;
                    bit_cnt_d = '0;
                    if (grp_inc_c == GRP_W'(GROUPS_PER_FRAME)) begin
                        state_d      = S_DONE;
                        go_d         = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt != GAP_W'(GAP_CYCLES)) begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end else if (!top_busy) begin
                    if (word_grp != '0) begin
                        // next group still sits in the shift register
                        signal_d   = sreg[0];
                        sreg_d     = sreg >> 1;
                        word_grp_d = word_grp - WG_W'(1);
                        bit_cnt_d  = BIT_W'(1);
                        state_d    = S_SHIFT;
                    end else if (!fifo_empty_c) begin
                        load_c = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Start a group from a freshly popped word: bit 0 goes out immediately
        if (load_c) begin
            pop_c      = 1'b1;
            signal_d   = fifo_head_c[0];
            sreg_d     = fifo_head_c >> 1;
            word_grp_d = WG_W'(WORD_GROUPS - 1);
            bit_cnt_d  = BIT_W'(1);
            go_d       = 1'b1;
            state_d    = S_SHIFT;
        end
    end

    // State, FIFO pointers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            grp_cnt    <= '0;
            gap_cnt    <= '0;
            word_grp   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready   <= 1'b0;
            signal_out <= 1'b0;
            go_out     <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            bit_cnt    <= bit_cnt_d;
            grp_cnt    <= grp_cnt_d;
            gap_cnt    <= gap_cnt_d;
            word_grp   <= word_grp_d;
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_d;
            in_ready   <= (count_d != CNT_W'(FIFO_DEPTH));
            signal_out <= signal_d;
            go_out     <= go_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_ofdm_bit_feeder.sv
// tb_ofdm_bit_feeder: directed-plus-random bench for ofdm_bit_feeder.
// A word queue models the FIFO; expected wire traces are built per frame
// from the queued words, the group/gap timing rules and the stall schedule.
module tb_ofdm_bit_feeder;

    localparam int DW   = 8;
    localparam int GB   = 4;
    localparam int GAP  = 5;
    localparam int GPF  = 8;
    localparam int DEP  = 4;
    localparam int WG   = DW / GB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          top_busy;
    logic          signal_out;
    logic          go_out;
    logic          frame_done;
    logic          underrun;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [DW-1:0] exp_q [$];
    int            gap_len [GPF-1];
    int            rise_cyc, done_cyc, last_acc_cyc;
    int            off, busy_at_m, busy_len_m;

    ofdm_bit_feeder #(
        .DATA_W(DW), .GROUP_BITS(GB), .GAP_CYCLES(GAP),
        .GROUPS_PER_FRAME(GPF), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .top_busy(top_busy), .signal_out(signal_out),
        .go_out(go_out), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic default_gaps();
        for (int i = 0; i < GPF - 1; i++) gap_len[i] = GAP;
    endtask

    // Push one word through the handshake; called and returns at a negedge
    task automatic push(input logic [DW-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready === 1'b1) begin
                last_acc_cyc = cyc;
                @(negedge clk);
                exp_q.push_back(w);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("push_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    // Advance one cycle, applying the optional top_busy window (offsets from go rise)
    task automatic step();
        @(negedge clk);
        off++;
        if (busy_at_m >= 0) begin
            if (off == busy_at_m)              top_busy = 1'b1;
            if (off == busy_at_m + busy_len_m) top_busy = 1'b0;
        end
    endtask

    // Expect one complete frame built from the next queued words
    task automatic check_frame(input string tag, input int busy_at, input int busy_len);
        logic [DW-1:0] w;
        bit rose;
        rose = 1'b0;
        w = '0;
        busy_at_m = busy_at;
        busy_len_m = busy_len;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (go_out === 1'b1) begin
                rose = 1'b1;
                break;
            end
        end
        if (!rose) begin
            chk($sformatf("%s_go_rise", tag), 32'(go_out), 32'd1);
            return;
        end
        rise_cyc = cyc;
        off = 0;
        for (int g = 0; g < GPF; g++) begin
            if (g % WG == 0) begin
                chk($sformatf("%s_word_avail_g%0d", tag, g), 32'(exp_q.size() > 0), 32'd1);
                w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            end
            for (int b = 0; b < GB; b++) begin
                chk($sformatf("%s_g%0d_b%0d", tag, g, b),
                    32'({go_out, signal_out, frame_done}),
                    32'({1'b1, w[(g % WG) * GB + b], 1'b0}));
                step();
            end
            if (g < GPF - 1) begin
                for (int k = 0; k < gap_len[g]; k++) begin
                    chk($sformatf("%s_gap%0d_c%0d", tag, g, k),
                        32'({go_out, signal_out, frame_done}), 32'(3'b100));
                    step();
                end
            end
        end
        chk($sformatf("%s_done", tag), 32'({go_out, signal_out, frame_done}), 32'(3'b001));
        done_cyc = cyc;
        busy_at_m = -1;
    endtask

    initial begin
        int first_acc, acc5, r1, d1, r2;
        bit rose;
        localparam int BUSY_AT  = 6;
        localparam int BUSY_LEN = 20;
        localparam int WAIT4    = 30;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; top_busy = 1'b0;
        busy_at_m = -1; busy_len_m = 0;
        default_gaps();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({in_ready, go_out, signal_out, frame_done, underrun}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // 1: fixed pattern, no stalls; bit 0 appears two cycles after the push cycle
        fork
            begin
                push(8'h93); first_acc = last_acc_cyc;
                push(8'h53); push(8'h93); push(8'h53);
            end
            check_frame("t1", -1, 0);
        join
        chk("t1_latency", 32'(rise_cyc - first_acc), 32'd2);

        // 2+6: fill FIFO while busy, 5th word held off, then two back-to-back frames
        top_busy = 1'b1;
        for (int i = 0; i < DEP; i++) push(DW'($urandom));
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        chk("t2_busy_no_go", 32'(go_out), 32'd0);
        in_data = DW'($urandom); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2_held_%0d", i), 32'(in_ready), 32'd0);
        end
        top_busy = 1'b0;
        fork
            begin
                push(in_data); acc5 = last_acc_cyc;
                for (int i = 0; i < 3; i++) push(DW'($urandom));
            end
            begin
                check_frame("t6a", -1, 0); r1 = rise_cyc; d1 = done_cyc;
                check_frame("t6b", -1, 0); r2 = rise_cyc;
            end
        join
        chk("t2_5th_accept", 32'(acc5 - r1), 32'd0);
        chk("t6_one_idle", 32'(r2 - d1), 32'd1);

        // 3: top_busy raised mid-gap; next group the cycle after it falls
        gap_len[0] = BUSY_AT + BUSY_LEN + 1 - GB;
        fork
            for (int i = 0; i < 4; i++) push(DW'($urandom));
            check_frame("t3", BUSY_AT, BUSY_LEN);
        join
        default_gaps();

        // 4: underrun after group 2 while the remaining words are late
        chk("t4_underrun_pre", 32'(underrun), 32'd0);
        gap_len[1] = (1 + WAIT4) - (2 * GB + GAP);
        fork
            begin
                push(DW'($urandom));
                repeat (WAIT4) @(negedge clk);
                for (int i = 0; i < 3; i++) push(DW'($urandom));
            end
            check_frame("t4", -1, 0);
        join
        default_gaps();
        chk("t4_underrun", 32'(underrun), 32'd1);

        // 5: reset during group 3, then a clean frame from fresh words
        rose = 1'b0;
        fork
            for (int i = 0; i < 4; i++) push(DW'($urandom));
            begin
                for (int i = 0; i < 300 && !rose; i++) begin
                    @(negedge clk);
                    if (go_out === 1'b1) rose = 1'b1;
                end
                repeat (2 * (GB + GAP) + 1) @(negedge clk);
            end
        join
        chk("t5_in_shift", 32'(go_out), 32'd1);
        #1 rst = 1'b0;
        #1 chk("t5_async_rst", 32'({in_ready, go_out, signal_out, frame_done, underrun}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_fifo_empty", 32'({go_out, in_ready}), 32'(2'b01));
        fork
            for (int i = 0; i < 4; i++) push(DW'($urandom));
            check_frame("t5", -1, 0);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
